aes_spi_responder: RTL and testbench

Serial responder front-end that connects a 128-bit AES datapath core to the single-bit chip-select/mosi/miso link driven by the top-level test master. It deserializes a 128-bit key and a 128-bit data block, hands both to the core with a start/done handshake, and serializes the 128-bit result back on miso after a fixed gap. The encryption and decryption slaves both use it, so link framing lives in one block.

---
 rtl/aes_spi_responder.sv | 160 ++++++++++++++++
 tb/tb_aes_spi_responder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/aes_spi_responder.sv
// Serial link front-end for a 128-bit AES core: receives key and text over cs_n/mosi,
// runs the core start/done handshake and returns the result on miso. Optional macro: AES_SPI_MISO_HIZ_EN.
module aes_spi_responder #(
  parameter int unsigned GAP_CYCLES = 56,
  parameter int unsigned BLOCK_BITS = 128
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cs_n,
  input  logic         mosi,
  output logic         miso,
  output logic [127:0] core_key,
  output logic [127:0] core_text,
  output logic         core_start,
  input  logic         core_done,
  input  logic [127:0] core_result,
  output logic         busy,
  output logic         timeout_err
);

  localparam int unsigned CW = $clog2(BLOCK_BITS);
  localparam int unsigned GW = $clog2(GAP_CYCLES);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RX_KEY  = 3'd1;
  localparam logic [2:0] S_RX_TEXT = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_TX      = 3'd4;

  logic [2:0]    state;
  logic [2:0]    state_next;
  logic [CW-1:0] bit_cnt;
  logic [GW-1:0] gap_cnt;
  logic [127:0]  key_sr;
  logic [126:0]  text_sr;
  logic [127:0]  tx_sr;
  logic          done_seen;
  logic          miso_q;
  logic          bit_last;
  logic          gap_last;

  assign bit_last = (bit_cnt == CW'(BLOCK_BITS - 1));
  assign gap_last = (gap_cnt == GW'(GAP_CYCLES - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; cs_n high aborts any active frame
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (!cs_n) state_next = S_RX_KEY;
      S_RX_KEY:  if (cs_n) state_next = S_IDLE; else if (bit_last) state_next = S_RX_TEXT;
      S_RX_TEXT: if (cs_n) state_next = S_IDLE; else if (bit_last) state_next = S_WAIT;
      S_WAIT:    if (cs_n) state_next = S_IDLE; else if (gap_last) state_next = S_TX;
      S_TX:      if (cs_n || bit_last) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Shift registers, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      key_sr      <= '0;
      text_sr     <= '0;
      tx_sr       <= '0;
      done_seen   <= 1'b0;
      miso_q      <= 1'b0;
      core_key    <= '0;
      core_text   <= '0;
      core_start  <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      core_start <= 1'b0;
      busy       <= (state_next != S_IDLE);
      if (cs_n && state != S_IDLE) begin
        bit_cnt   <= '0;
        gap_cnt   <= '0;
        done_seen <= 1'b0;
        miso_q    <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (!cs_n) begin
              key_sr  <= {key_sr[126:0], mosi};
              bit_cnt <= CW'(1);
            end
          end
          S_RX_KEY: begin
            key_sr  <= {key_sr[126:0], mosi};
            bit_cnt <= bit_last ? '0 : bit_cnt + CW'(1);
          end
          S_RX_TEXT: begin
            text_sr <= {text_sr[125:0], mosi};
            if (bit_last) begin
              core_key    <= key_sr;
              core_text   <= {text_sr, mosi};
              core_start  <= 1'b1;
              timeout_err <= 1'b0;
              gap_cnt     <= '0;
              done_seen   <= 1'b0;
              bit_cnt     <= '0;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
          S_WAIT: begin
            // A done arriving on the final gap edge is too late to be serialized
            if (gap_last) begin
              gap_cnt <= '0;
              bit_cnt <= '0;
              if (done_seen) begin
                miso_q <= tx_sr[127];
                tx_sr  <= {tx_sr[126:0], 1'b0};
              end else begin
                timeout_err <= 1'b1;
                miso_q      <= 1'b0;
                tx_sr       <= '0;
              end
            end else begin
              gap_cnt <= gap_cnt + GW'(1);
              if (core_done && !done_seen) begin
                tx_sr     <= core_result;
                done_seen <= 1'b1;
              end
            end
          end
          S_TX: begin
            if (bit_last) begin
              miso_q    <= 1'b0;
              bit_cnt   <= '0;
              done_seen <= 1'b0;
            end else begin
              miso_q  <= tx_sr[127];
              tx_sr   <= {tx_sr[126:0], 1'b0};
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
          default: begin
            bit_cnt <= '0;
            gap_cnt <= '0;
          end
        endcase
      end
    end
  end

`ifdef AES_SPI_MISO_HIZ_EN
  assign miso = (state == S_TX && !cs_n) ? miso_q : 1'bz;
`else
  assign miso = miso_q;
`endif

endmodule

// File: tb/tb_aes_spi_responder.sv
// Randomized bench for aes_spi_responder: drives whole frames edge by edge and checks
// every output against the frame timeline computed from the edge number.
module tb_aes_spi_responder;

  localparam int unsigned G = 56;
  localparam int LAST = 383 + G;

`ifdef AES_SPI_MISO_HIZ_EN
  localparam logic IDLE_MISO = 1'bz;
`else
  localparam logic IDLE_MISO = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         cs_n;
  logic         mosi;
  wire          miso;
  logic [127:0] core_key;
  logic [127:0] core_text;
  logic         core_start;
  logic         core_done;
  logic [127:0] core_result;
  logic         busy;
  logic         timeout_err;

  int   checks = 0;
  int   failures = 0;
  logic tb_timeout;

  aes_spi_responder #(.GAP_CYCLES(G), .BLOCK_BITS(128)) dut (
    .clk(clk), .reset(reset), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .core_key(core_key), .core_text(core_text), .core_start(core_start),
    .core_done(core_done), .core_result(core_result), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk_reset_values(input string tag);
    chk({tag, "_key"}, core_key, '0);
    chk({tag, "_text"}, core_text, '0);
    chk({tag, "_start"}, 128'(core_start), '0);
    chk({tag, "_busy"}, 128'(busy), '0);
    chk({tag, "_to"}, 128'(timeout_err), '0);
    chk({tag, "_miso"}, 128'(miso), 128'(IDLE_MISO));
  endtask

  // One frame: edge e numbered from the first cs_n-low edge; abort/reset edges optional (-1 = none)
  task automatic run_frame(input logic [127:0] key, input logic [127:0] text,
                           input logic [127:0] result, input int done_at,
                           input int abort_at, input int reset_at, input bit hold_cs);
    logic         exp_to;
    logic [127:0] exp_tx;
    exp_to = !(done_at >= 0 && done_at <= int'(G) - 2);
    exp_tx = exp_to ? '0 : result;
    for (int e = 0; e <= LAST; e++) begin
      cs_n  = (e == abort_at);
      reset = (e == reset_at);
      if (e < 128)      mosi = key[127 - e];
      else if (e < 256) mosi = text[255 - e];
      else              mosi = 1'($urandom);
      core_done   = 1'b0;
      core_result = rnd128();
      if (e < 256 && $urandom_range(15) == 0) core_done = 1'b1;
      if (done_at >= 0 && e == 256 + done_at) begin
        core_done   = 1'b1;
        core_result = result;
      end else if (done_at >= 0 && e == 257 + done_at) begin
        core_done   = 1'b1;
        core_result = ~result;
      end
      tick();
      if (e == reset_at) begin
        chk_reset_values("reset_mid");
        reset      = 1'b0;
        tb_timeout = 1'b0;
        return;
      end
      if (e == 255) tb_timeout = 1'b0;
      if (e == 255 + int'(G)) tb_timeout = exp_to;
      if (e == abort_at) begin
        chk("abort_busy", 128'(busy), '0);
        chk("abort_start", 128'(core_start), '0);
        chk("abort_miso", 128'(miso), 128'(IDLE_MISO));
        chk("abort_to", 128'(timeout_err), 128'(tb_timeout));
        return;
      end
      chk("busy", 128'(busy), 128'(e != LAST));
      chk("start", 128'(core_start), 128'(e == 255));
      chk("timeout", 128'(timeout_err), 128'(tb_timeout));
      if (e == 255 || e == LAST) begin
        chk("core_key", core_key, key);
        chk("core_text", core_text, text);
      end
      if (e >= 255 + int'(G) && e <= 382 + int'(G))
        chk("miso_bit", 128'(miso), 128'(exp_tx[127 - (e - 255 - int'(G))]));
      else
        chk("miso_idle", 128'(miso), 128'(IDLE_MISO));
    end
    if (!hold_cs) begin
      cs_n      = 1'b1;
      core_done = 1'b0;
      tick();
      chk("gap_busy", 128'(busy), '0);
      chk("gap_miso", 128'(miso), 128'(IDLE_MISO));
    end
  endtask

  initial begin
    logic [127:0] k0, t0, r0;
    int           d, a;
    k0 = 128'h000102030405060708090a0b0c0d0e0f;
    t0 = 128'h00112233445566778899aabbccddeeff;
    r0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    reset = 1'b1; cs_n = 1'b1; mosi = 1'b0; core_done = 1'b0; core_result = '0;
    tb_timeout = 1'b0;
    tick();
    tick();
    chk_reset_values("reset");
    reset = 1'b0;

    // Reference vector, done at gap cycle 10
    run_frame(k0, t0, r0, 10, -1, -1, 1'b0);

    // Done withheld, then a late done while idle must not disturb anything
    run_frame(k0, t0, r0, -1, -1, -1, 1'b0);
    core_done = 1'b1; core_result = r0;
    tick();
    core_done = 1'b0;
    tick();
    chk("late_done_to", 128'(timeout_err), 128'(1'b1));
    chk("late_done_busy", 128'(busy), '0);

    // Abort in text phase, then a clean frame
    run_frame(k0, t0, r0, 10, 201, -1, 1'b0);
    run_frame(rnd128(), rnd128(), rnd128(), 30, -1, -1, 1'b0);

    // Reset during TX, then a clean frame
    run_frame(k0, t0, r0, 10, -1, 350, 1'b0);
    run_frame(k0, t0, r0, 5, -1, -1, 1'b0);

    // Back-to-back frames with cs_n held low
    run_frame(k0, t0, r0, 10, -1, -1, 1'b1);
    run_frame(k0, r0, rnd128(), 20, -1, -1, 1'b0);

    // Deadline boundaries: last legal gap cycle and the final gap edge
    run_frame(rnd128(), rnd128(), rnd128(), int'(G) - 2, -1, -1, 1'b0);
    run_frame(rnd128(), rnd128(), rnd128(), int'(G) - 1, -1, -1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(4))
        0:       d = -1;
        1:       d = int'(G) - 1;
        2:       d = int'(G) - 2;
        3:       d = 0;
        default: d = int'($urandom_range(G - 3, 1));
      endcase
      a = ($urandom_range(2) == 0) ? int'($urandom_range(LAST, 1)) : -1;
      run_frame(rnd128(), rnd128(), rnd128(), d, a, -1, 1'($urandom));
    end

    cs_n = 1'b1;
    tick();
    chk("end_busy", 128'(busy), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
